// File: rtl/packet_fifo.sv
`default_nettype none
// ============================================================================
// packet_fifo : synchronous FIFO with staged packet writes (commit / discard)
// Revision    : 1.0
// ============================================================================
module packet_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int AF_THRESH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     commit,
  input  logic                     discard,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   free,
  output logic                     pkt_err,
  output logic                     commit_drop,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);
  localparam int unsigned C_AF    = AF_THRESH;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] cm_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] used;
  logic [AW:0] wr_next;

  logic wr_acc;
  logic wr_ovf;
  logic rd_acc;
  logic drop_commit;
  logic rollback;

  // Status is derived purely from registered pointers; no input reaches an output.
  assign used        = wr_ptr - rd_ptr;
  assign full        = (used == C_DEPTH);
  assign empty       = (cm_ptr == rd_ptr);
  assign free        = C_DEPTH - used;
  assign count       = cm_ptr - rd_ptr;
  assign almost_full = (32'(free) <= C_AF);

  assign wr_acc      = wr_en && !full;
  assign wr_ovf      = wr_en && full;
  assign rd_acc      = rd_en && !empty;
  assign drop_commit = commit && !discard && (pkt_err || wr_ovf);
  assign rollback    = discard || drop_commit;
  assign wr_next     = wr_acc ? (wr_ptr + C_ONE) : wr_ptr;

  // A write landing in a packet that is rolled back only touches free space.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      rd_data     <= '0;
      pkt_err     <= 1'b0;
      commit_drop <= 1'b0;
    end else begin
      commit_drop <= drop_commit;

      if (rollback) begin
        wr_ptr  <= cm_ptr;
        pkt_err <= 1'b0;
      end else if (commit) begin
        wr_ptr  <= wr_next;
        cm_ptr  <= wr_next;
        pkt_err <= 1'b0;
      end else begin
        wr_ptr <= wr_next;
        if (wr_ovf) begin
          pkt_err <= 1'b1;
        end
      end

      if (rd_acc) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + C_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_fifo.sv
`default_nettype none
// ============================================================================
// tb_packet_fifo : self-checking bench for packet_fifo (DEPTH=8, AF_THRESH=2)
// Revision       : 1.0
// ============================================================================
module tb_packet_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       discard = 1'b0;
  logic       rd_en = 1'b0;
  logic       full, almost_full, pkt_err, commit_drop, empty;
  logic [3:0] free, count;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model: staged and committed words, sticky error, last read value.
  logic [7:0] sq[$];
  logic [7:0] cq[$];
  logic       m_err = 1'b0;
  logic       m_drop = 1'b0;
  logic [7:0] m_rd = '0;
  int         n_rd = 0;

  packet_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .commit(commit), .discard(discard), .full(full),
    .almost_full(almost_full), .free(free), .pkt_err(pkt_err),
    .commit_drop(commit_drop), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic wr, input logic [7:0] d, input logic cm,
                       input logic ds, input logic rd);
    int   used;
    logic wacc, wovf, drop;
    used = sq.size() + cq.size();
    wr_en = wr; wr_data = d; commit = cm; discard = ds; rd_en = rd;
    if (rd && cq.size() != 0) begin
      m_rd = cq.pop_front();
      n_rd++;
    end
    wacc = wr && (used != 8);
    wovf = wr && (used == 8);
    drop = cm && !ds && (m_err || wovf);
    if (ds || drop) begin
      sq.delete();
      m_err = 1'b0;
    end else if (cm) begin
      if (wacc) sq.push_back(d);
      foreach (sq[i]) cq.push_back(sq[i]);
      sq.delete();
      m_err = 1'b0;
    end else begin
      if (wacc) sq.push_back(d);
      if (wovf) m_err = 1'b1;
    end
    m_drop = drop;
    @(posedge clk);
    #1;
    wr_en = 1'b0; commit = 1'b0; discard = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sq.delete(); cq.delete();
    m_err = 1'b0; m_drop = 1'b0; m_rd = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
    checks++; if (free !== 4'd8) begin errors++; $display("FAIL rst_free: got %0d want 8", free); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b want 0", almost_full); end
    checks++; if (pkt_err !== 1'b0 || commit_drop !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b want 00", pkt_err, commit_drop); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
  endtask

  task automatic test_basic();
    logic [7:0] pkt [3];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pkt[i], 1'b0, 1'b0, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_staged%0d: got %b want 1", i, empty); end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty_commit: got %b want 0", empty); end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
    checks++; if (free !== 4'd5) begin errors++; $display("FAIL basic_free: got %0d want 5", free); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (rd_data !== pkt[i]) begin errors++; $display("FAIL basic_rd%0d: got %h want %h", i, rd_data, pkt[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after: got %b want 1", empty); end
    checks++; if (free !== 4'd8) begin errors++; $display("FAIL basic_free_after: got %0d want 8", free); end
  endtask

  task automatic test_discard();
    drive(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (free !== 4'd3) begin errors++; $display("FAIL disc_free_staged: got %0d want 3", free); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (free !== 4'd6) begin errors++; $display("FAIL disc_free: got %0d want 6", free); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL disc_count: got %0d want 2", count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hA1) begin errors++; $display("FAIL disc_rd0: got %h want a1", rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hA2) begin errors++; $display("FAIL disc_rd1: got %h want a2", rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hA2 || empty !== 1'b1) begin errors++; $display("FAIL disc_rd_hold: got %h/%b want a2/1", rd_data, empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 6) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full7: got %b want 0", full); end
      end
    end
    checks++; if (full !== 1'b1 || pkt_err !== 1'b0) begin errors++; $display("FAIL ovf_full8: got full=%b err=%b want 1/0", full, pkt_err); end
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL ovf_pkt_err: got %b want 1", pkt_err); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (commit_drop !== 1'b1) begin errors++; $display("FAIL ovf_drop: got %b want 1", commit_drop); end
    checks++; if (count !== 4'd0 || free !== 4'd8) begin errors++; $display("FAIL ovf_ptrs: got count=%0d free=%0d want 0/8", count, free); end
    checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL ovf_err_clr: got %b want 0", pkt_err); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (commit_drop !== 1'b0) begin errors++; $display("FAIL ovf_drop_pulse: got %b want 0", commit_drop); end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL sim_wr_commit: got %0d want 1", count); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL sim_rd: got %h want 5a", rd_data); end
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++; if (free !== 4'd8) begin errors++; $display("FAIL sim_wr_discard: got %0d want 8", free); end
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (count !== 4'd0 || free !== 4'd8 || commit_drop !== 1'b0) begin errors++; $display("FAIL sim_cm_ds: got count=%0d free=%0d drop=%b want 0/8/0", count, free, commit_drop); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (count !== 4'd0 || free !== 4'd8) begin errors++; $display("FAIL sim_empty_commit: got count=%0d free=%0d want 0/8", count, free); end
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hC0 + 8'(i), (i == 7), 1'b0, 1'b0);
    checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL sim_fill: got count=%0d full=%b want 8/1", count, full); end
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hC0 || pkt_err !== 1'b1 || free !== 4'd1 || full !== 1'b0) begin errors++; $display("FAIL sim_rdwr_full: got %h err=%b free=%0d full=%b want c0/1/1/0", rd_data, pkt_err, free, full); end
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checks++; if (pkt_err !== 1'b0 || count !== 4'd7) begin errors++; $display("FAIL sim_clr: got err=%b count=%0d want 0/7", pkt_err, count); end
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (rd_data !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL sim_drain%0d: got %h want %h", i, rd_data, 8'hC0 + 8'(i)); end
    end
  endtask

  task automatic test_wrap();
    int pk = 0, left = 0, pend = 0, written = 0, rd_start, used, cyc;
    logic       wr, cm, rd;
    logic [7:0] d;
    logic [3:0] e_free, e_count;
    rd_start = n_rd;
    for (cyc = 0; cyc < 3000 && (pk < 40 || cq.size() != 0 || sq.size() != 0); cyc++) begin
      wr = 1'b0; cm = 1'b0; d = 8'($urandom);
      used = sq.size() + cq.size();
      if (left == 0 && pend == 0 && pk < 40) pend = $urandom_range(1, 7);
      if (left == 0 && pend != 0 && (8 - used) >= pend) begin
        left = pend; pend = 0;
      end
      if (left > 0) begin
        wr = 1'b1; cm = (left == 1); left--; written++;
        if (left == 0) pk++;
      end
      rd = ($urandom_range(0, 3) != 0);
      drive(wr, d, cm, 1'b0, rd);
      used    = sq.size() + cq.size();
      e_free  = 4'(8 - used);
      e_count = 4'(cq.size());
      checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL wrap_data c%0d: got %h want %h", cyc, rd_data, m_rd); end
      checks++; if (free !== e_free || count !== e_count) begin errors++; $display("FAIL wrap_levels c%0d: got free=%0d count=%0d want %0d/%0d", cyc, free, count, e_free, e_count); end
      checks++; if (full !== (used == 8) || empty !== (cq.size() == 0)) begin errors++; $display("FAIL wrap_flags c%0d: got full=%b empty=%b want %b/%b", cyc, full, empty, used == 8, cq.size() == 0); end
      checks++; if (almost_full !== (e_free <= 4'd2)) begin errors++; $display("FAIL wrap_af c%0d: got %b want %b", cyc, almost_full, e_free <= 4'd2); end
      checks++; if (pkt_err !== 1'b0 || commit_drop !== 1'b0) begin errors++; $display("FAIL wrap_err c%0d: got %b%b want 00", cyc, pkt_err, commit_drop); end
    end
    checks++; if (pk != 40 || cq.size() != 0 || sq.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d packets want 40 drained", pk); end
    checks++; if ((n_rd - rd_start) != written || written <= 16) begin errors++; $display("FAIL wrap_total: got %0d reads want %0d (>16)", n_rd - rd_start, written); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hD2 + 8'(i), (i == 2), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b1, 8'hF0 + 8'(i), 1'b0, 1'b0, 1'b0);
    checks++; if (count !== 4'd3 || free !== 4'd3) begin errors++; $display("FAIL mid_pre: got count=%0d free=%0d want 3/3", count, free); end
    do_reset();
    checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0 || free !== 4'd8) begin errors++; $display("FAIL mid_rst_lvl: got e=%b f=%b c=%0d fr=%0d want 1/0/0/8", empty, full, count, free); end
    checks++; if (rd_data !== 8'h00 || almost_full !== 1'b0 || pkt_err !== 1'b0 || commit_drop !== 1'b0) begin errors++; $display("FAIL mid_rst_out: got %h af=%b err=%b drop=%b want 00/0/0/0", rd_data, almost_full, pkt_err, commit_drop); end
    drive(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hE2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hE1) begin errors++; $display("FAIL mid_rd0: got %h want e1", rd_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (rd_data !== 8'hE2 || empty !== 1'b1) begin errors++; $display("FAIL mid_rd1: got %h/%b want e2/1", rd_data, empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
